// File: rtl/forest_vote_accumulator_pkg.sv
// Shared constants, width helpers and FSM encoding for the forest vote accumulator.
// The default class/tree counts match the decision-tree bank upstream.
package forest_pkg;

    localparam int N_CLASSES = 7;
    localparam int N_TREES   = 4;

    // Class index width. It is never narrower than one bit.
    function automatic int cls_w(input int n_classes);
        return (n_classes <= 2) ? 1 : $clog2(n_classes);
    endfunction

    // Vote-count width. It holds every value from 0 to n_trees.
    function automatic int cnt_w(input int n_trees);
        return (n_trees <= 1) ? 1 : $clog2(n_trees + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } vote_state_t;

endpackage

// File: rtl/forest_vote_accumulator_if.sv
// Sample-in / result-out handshake bundle of the forest vote accumulator.
// Master drives samples and consumes results; slave is the accumulator.
interface forest_vote_accumulator_if #(
    parameter int N_CLASSES = forest_pkg::N_CLASSES,
    parameter int N_TREES   = forest_pkg::N_TREES
);
    localparam int CLS_W = forest_pkg::cls_w(N_CLASSES);
    localparam int CNT_W = forest_pkg::cnt_w(N_TREES);

    logic [N_CLASSES*N_TREES-1:0] in_votes;
    logic                         in_valid;
    logic                         in_ready;
    logic [CLS_W-1:0]             out_class;
    logic [CNT_W-1:0]             out_count;
    logic                         out_tie;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_votes, in_valid, out_ready,
        input  in_ready, out_class, out_count, out_tie, out_valid
    );

    modport slave (
        input  in_votes, in_valid, out_ready,
        output in_ready, out_class, out_count, out_tie, out_valid
    );

endinterface

// File: rtl/forest_vote_accumulator_popcount.sv
// Combinational popcount of the per-class slice selected by idx.
// An idx outside the class range reads as an empty slice.
module forest_popcount #(
    parameter  int N_CLASSES = forest_pkg::N_CLASSES,
    parameter  int N_TREES   = forest_pkg::N_TREES,
    localparam int CLS_W     = forest_pkg::cls_w(N_CLASSES),
    localparam int CNT_W     = forest_pkg::cnt_w(N_TREES)
) (
    input  logic [N_CLASSES*N_TREES-1:0] votes,
    input  logic [CLS_W-1:0]             idx,
    output logic [CNT_W-1:0]             cnt
);

    logic [N_TREES-1:0] slice;

    always_comb begin
        slice = '0;
        for (int c = 0; c < N_CLASSES; c++) begin
            if (idx == CLS_W'(c)) slice = votes[c*N_TREES +: N_TREES];
        end
    end

    always_comb begin
        cnt = '0;
        for (int t = 0; t < N_TREES; t++) begin
            cnt = cnt + CNT_W'(slice[t]);
        end
    end

endmodule

// File: rtl/forest_vote_accumulator.sv
// Registers one vote vector and scans one class per cycle for the most-voted class.
// A tie resolves to the lowest class index, and the tie flag reports it.
module forest_vote_accumulator #(
    parameter int N_CLASSES = forest_pkg::N_CLASSES,
    parameter int N_TREES   = forest_pkg::N_TREES
) (
    input logic                      clk,
    input logic                      rst,
    forest_vote_accumulator_if.slave bus
);
    import forest_pkg::*;

    localparam int CLS_W = cls_w(N_CLASSES);
    localparam int CNT_W = cnt_w(N_TREES);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SCAN = SCAN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(N_CLASSES - 1);

    logic [1:0]                   state_q;
    logic [N_CLASSES*N_TREES-1:0] vote_q;
    logic [CLS_W-1:0]             idx_q;
    logic [CLS_W-1:0]             cls_q;
    logic [CNT_W-1:0]             max_q;
    logic                         tie_q;
    logic [CNT_W-1:0]             cnt;

    forest_popcount #(
        .N_CLASSES (N_CLASSES),
        .N_TREES   (N_TREES)
    ) u_popcount (
        .votes (vote_q),
        .idx   (idx_q),
        .cnt   (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vote_q  <= '0;
            idx_q   <= '0;
            cls_q   <= '0;
            max_q   <= '0;
            tie_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        vote_q  <= bus.in_votes;
                        idx_q   <= '0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (idx_q == '0) begin
                        max_q <= cnt;
                        cls_q <= '0;
                        tie_q <= 1'b0;
                    end else if (cnt > max_q) begin
                        max_q <= cnt;
                        cls_q <= idx_q;
                        tie_q <= 1'b0;
                    end else if (cnt == max_q) begin
                        tie_q <= 1'b1;
                    end
                    // idx parks on the last class so it never wraps.
                    if (idx_q == LAST_IDX) state_q <= ST_DONE;
                    else                   idx_q   <= idx_q + 1'b1;
                end
                ST_DONE: begin
                    if (bus.out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_class = cls_q;
    assign bus.out_count = max_q;
    assign bus.out_tie   = tie_q;

endmodule
